// File: rtl/task_enq_responder.sv
// rtl/task_enq_responder.sv - task-enqueue responder: free-list slot allocation, TQ write and ACK/NACK response
// Free list: FIFO of {slot, epoch} with a registered first-word-fall-through head.
module task_enq_free_list #(
  parameter int LOG_SLOTS   = 12,
  parameter int EPOCH_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [LOG_SLOTS-1:0]   push_slot,
  input  logic [EPOCH_WIDTH-1:0] push_epoch,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [LOG_SLOTS-1:0]   head_slot,
  output logic [EPOCH_WIDTH-1:0] head_epoch,
  output logic [LOG_SLOTS:0]     count
);
  localparam int N = 1 << LOG_SLOTS;
  localparam int ENTRY_W = LOG_SLOTS + EPOCH_WIDTH;

  logic [ENTRY_W-1:0]   mem [N];
  logic [LOG_SLOTS-1:0] wr_ptr;
  logic [LOG_SLOTS-1:0] rd_ptr;
  logic [LOG_SLOTS:0]   mem_count;
  logic [ENTRY_W-1:0]   head_data;
  logic                 refresh;

  // The head only reloads from entries already stored, so a same-cycle push is never visible here.
  assign refresh = (!head_valid || pop) && (mem_count != '0);
  assign count = mem_count + (LOG_SLOTS+1)'(head_valid);
  assign head_slot = head_data[ENTRY_W-1:EPOCH_WIDTH];
  assign head_epoch = head_data[EPOCH_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push_valid) begin
      mem[wr_ptr] <= {push_slot, push_epoch};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (refresh) begin
        head_data  <= mem[rd_ptr];
        head_valid <= 1'b1;
        rd_ptr     <= rd_ptr + 1'b1;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
      mem_count <= mem_count + (LOG_SLOTS+1)'(push_valid) - (LOG_SLOTS+1)'(refresh);
    end
  end
endmodule

module task_enq_responder #(
  parameter int LOG_SLOTS    = 12,
  parameter int RESERVE      = 4,
  parameter int TQ_WIDTH     = 64,
  parameter int EPOCH_WIDTH  = 8,
  parameter int LOG_TSB_SIZE = 4,
  parameter int LOG_N_TILES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [TQ_WIDTH-1:0]     enq_task,
  input  logic                    enq_tied,
  input  logic [LOG_TSB_SIZE-1:0] enq_tsb_id,
  input  logic [LOG_N_TILES-1:0]  enq_src_tile,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LOG_N_TILES-1:0]  resp_dest_tile,
  output logic [LOG_TSB_SIZE-1:0] resp_tsb_id,
  output logic                    resp_ack,
  output logic [EPOCH_WIDTH-1:0]  resp_epoch,
  output logic [LOG_SLOTS-1:0]    resp_slot,
  output logic                    tq_wr_valid,
  output logic [LOG_SLOTS-1:0]    tq_wr_slot,
  output logic [TQ_WIDTH-1:0]     tq_wr_task,
  output logic                    tq_wr_tied,
  output logic [EPOCH_WIDTH-1:0]  tq_wr_epoch,
  input  logic                    free_valid,
  input  logic [LOG_SLOTS-1:0]    free_slot,
  input  logic [EPOCH_WIDTH-1:0]  free_epoch,
  output logic [LOG_SLOTS:0]      free_count,
  output logic                    err_overflow
);
  localparam int N = 1 << LOG_SLOTS;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [LOG_SLOTS-1:0]   init_idx;
  logic                   in_init;
  logic                   in_run;
  logic                   accept;
  logic                   grant;
  logic                   pop;
  logic                   list_full;
  logic                   push_valid;
  logic [LOG_SLOTS-1:0]   push_slot;
  logic [EPOCH_WIDTH-1:0] push_epoch;
  logic                   head_valid;
  logic [LOG_SLOTS-1:0]   head_slot;
  logic [EPOCH_WIDTH-1:0] head_epoch;
  logic [LOG_SLOTS:0]     total;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_idx == LOG_SLOTS'(N - 1)) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    in_init   = (state_q == S_INIT);
    in_run    = (state_q == S_RUN);
    enq_ready = in_run && (!resp_valid || resp_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx <= '0;
    end else if (in_init) begin
      init_idx <= init_idx + 1'b1;
    end
  end

  // Untied tasks must leave RESERVE slots behind; tied tasks may take the last one.
  assign accept     = enq_valid && enq_ready;
  assign grant      = head_valid && (enq_tied || total > (LOG_SLOTS+1)'(RESERVE));
  assign pop        = accept && grant;
  assign list_full  = (total == (LOG_SLOTS+1)'(N));
  assign push_valid = in_init || (in_run && free_valid && !list_full);
  assign push_slot  = in_init ? init_idx : free_slot;
  assign push_epoch = in_init ? '0 : free_epoch + 1'b1;
  assign free_count = in_run ? total : '0;

  task_enq_free_list #(
    .LOG_SLOTS   (LOG_SLOTS),
    .EPOCH_WIDTH (EPOCH_WIDTH)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_slot  (push_slot),
    .push_epoch (push_epoch),
    .pop        (pop),
    .head_valid (head_valid),
    .head_slot  (head_slot),
    .head_epoch (head_epoch),
    .count      (total)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_dest_tile <= '0;
      resp_tsb_id    <= '0;
      resp_ack       <= 1'b0;
      resp_epoch     <= '0;
      resp_slot      <= '0;
    end else if (accept) begin
      resp_valid     <= 1'b1;
      resp_dest_tile <= enq_src_tile;
      resp_tsb_id    <= enq_tsb_id;
      resp_ack       <= grant;
      resp_epoch     <= grant ? head_epoch : '0;
      resp_slot      <= grant ? head_slot : '0;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tq_wr_valid <= 1'b0;
      tq_wr_slot  <= '0;
      tq_wr_task  <= '0;
      tq_wr_tied  <= 1'b0;
      tq_wr_epoch <= '0;
    end else begin
      tq_wr_valid <= pop;
      if (pop) begin
        tq_wr_slot  <= head_slot;
        tq_wr_task  <= enq_task;
        tq_wr_tied  <= enq_tied;
        tq_wr_epoch <= head_epoch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
    end else if (in_run && free_valid && list_full) begin
      err_overflow <= 1'b1;
    end
  end
endmodule
